// File: rtl/alu_issue_stage.sv
// alu_issue_stage: MIPS-style ALU operand decode feeding a 2-entry skid buffer toward the ALU
module alu_issue_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs_val,
  input  logic [31:0]      in_rt_val,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inA,
  output logic [31:0]      out_inB,
  output logic [2:0]       out_ALUControl,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t r_state, w_next;
  logic [67:0] r_head, r_tail, w_dec;
  logic [31:0] w_a, w_b, w_se, w_ze;
  logic [2:0] w_ctl;
  logic w_ill, w_acc, w_drain;
  logic [5:0] w_op, w_fn;
  logic [CNT_W-1:0] r_cnt;
  assign w_op = in_instr[31:26];
  assign w_fn = in_instr[5:0];
  assign w_se = {{16{in_instr[15]}}, in_instr[15:0]};
  assign w_ze = {16'b0, in_instr[15:0]};
  assign w_dec = {w_a, w_b, w_ctl, w_ill};
  assign in_ready = r_state != FULL;
  assign out_valid = r_state != EMPTY;
  assign w_acc = in_valid && in_ready;
  assign w_drain = out_valid && out_ready;
  assign {out_inA, out_inB, out_ALUControl, out_illegal} = r_head;
  assign illegal_count = r_cnt;
  // Combinational decode of the incoming instruction into an ALU bundle; illegal words get zeroed operands
  always_comb begin
    w_ctl = 3'b000;
    w_ill = 1'b0;
    w_a = in_rs_val;
    w_b = in_rt_val;
    case (w_op)
      6'h00: case (w_fn)
        6'h20, 6'h21: w_ctl = 3'b010;
        6'h22, 6'h23: w_ctl = 3'b110;
        6'h24:        w_ctl = 3'b000;
        6'h25:        w_ctl = 3'b001;
        6'h26:        w_ctl = 3'b100;
        6'h2A:        w_ctl = 3'b111;
        default:      w_ill = 1'b1;
      endcase
      6'h08, 6'h09, 6'h23, 6'h2B: begin w_ctl = 3'b010; w_b = w_se; end
      6'h0A: begin w_ctl = 3'b111; w_b = w_se; end
      6'h0C: begin w_ctl = 3'b000; w_b = w_ze; end
      6'h0D: begin w_ctl = 3'b001; w_b = w_ze; end
      6'h0E: begin w_ctl = 3'b100; w_b = w_ze; end
      6'h04, 6'h05: w_ctl = 3'b110;
      default: w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_ctl = 3'b000;
      w_a = '0;
      w_b = '0;
    end
  end
  // Buffer occupancy next-state; flush wins over any accept or drain
  always_comb begin
    w_next = r_state;
    if (flush) w_next = EMPTY;
    else case (r_state)
      EMPTY:   w_next = w_acc ? ONE : EMPTY;
      ONE:     w_next = (w_acc && !w_drain) ? FULL : (!w_acc && w_drain) ? EMPTY : ONE;
      FULL:    w_next = w_drain ? ONE : FULL;
      default: w_next = EMPTY;
    endcase
  end
  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else r_state <= w_next;
  end
  // Head holds the oldest entry and only moves on fill-from-empty, pass-through, or drain from FULL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (!flush) begin
      if (w_acc && (r_state == EMPTY || (r_state == ONE && w_drain))) r_head <= w_dec;
      else if (r_state == FULL && w_drain) r_head <= r_tail;
      if (w_acc && r_state == ONE && !w_drain) r_tail <= w_dec;
    end
  end
  // Saturating count of illegal instructions actually kept in the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (w_acc && w_ill && !flush && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter: CNT_W, default 8, width of the illegal-instruction counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream instruction/operand bundle valid.
REQ-005 in_ready  output  1  stage can accept a bundle this cycle.
REQ-006 in_instr  input  32  MIPS-style instruction word.
REQ-007 in_rs_val, in_rt_val  input  32 each  register operand values for rs and rt.
REQ-008 flush  input  1  discard all buffered and incoming bundles.
REQ-009 out_valid  output  1  ALU operand bundle valid.
REQ-010 out_ready  input  1  ALU side consumes the bundle this cycle.
REQ-011 out_inA, out_inB  output  32 each  ALU operands.
REQ-012 out_ALUControl  output  3  ALU operation code.
REQ-013 out_illegal  output  1  bundle came from an undecodable instruction.
REQ-014 illegal_count  output  CNT_W  saturating count of accepted illegal instructions.

Function
REQ-015 ALUControl encoding: 000 AND, 001 OR, 010 ADD, 100 XOR, 101 XNOR, 110 SUB, 111 SLT; code 011 shall never be emitted.
REQ-016 R-type (opcode 0): funct 0x20/0x21 -> 010, 0x22/0x23 -> 110, 0x24 -> 000, 0x25 -> 001, 0x26 -> 100, 0x2A -> 111; inA=rs_val, inB=rt_val.
REQ-017 I-type: 0x08/0x09/0x23/0x2B -> 010 with sign-extended imm16; 0x0A -> 111 sign-extended; 0x0C -> 000, 0x0D -> 001, 0x0E -> 100 zero-extended; inA=rs_val, inB=extended imm.
REQ-018 opcode 0x04/0x05 -> 110, inA=rs_val, inB=rt_val.
REQ-019 Any other opcode/funct: illegal; ALUControl=000, inA=0, inB=0, out_illegal=1.
REQ-020 Decode is combinational on input; the decoded bundle is stored at acceptance (in_valid && in_ready).
REQ-021 Storage: 2-entry FIFO skid buffer; states EMPTY, ONE, FULL.
REQ-022 in_ready = 1 in EMPTY and ONE, 0 in FULL; depends on state only, not on out_ready.
REQ-023 out_valid = 1 in ONE and FULL; outputs present the oldest entry.
REQ-024 Latency: bundle accepted in cycle N appears on outputs in cycle N+1 if the buffer was empty.
REQ-025 Transitions: EMPTY+accept -> ONE; ONE+accept only -> FULL; ONE+drain only -> EMPTY; ONE+accept+drain -> ONE (new entry becomes head); FULL+drain -> ONE; otherwise hold.
REQ-026 Drain = out_valid && out_ready; while out_valid && !out_ready all out_* shall remain stable.
REQ-027 Order preserved: bundles leave in acceptance order; none lost or duplicated.
REQ-028 flush asserted: next state EMPTY regardless of accept/drain that cycle; a same-cycle accept is discarded.
REQ-029 illegal_count increments by 1 on acceptance of an illegal instruction, not when flush is asserted that cycle; saturates at 2^CNT_W-1.
REQ-030 illegal_count is unaffected by flush of already-buffered entries.

Reset
REQ-031 rst_n low asynchronously forces: state EMPTY, out_valid=0, in_ready=1, out_inA=0, out_inB=0, out_ALUControl=000, out_illegal=0, illegal_count=0.
REQ-032 Reset mid-operation discards all buffered entries; first bundle after release follows REQ-024.

Verification
REQ-033 add (op 0, funct 0x20), rs=5, rt=7, out_ready=1 -> next cycle out_valid=1, ALUControl=010, inA=5, inB=7.
REQ-034 slti imm=0xFFFF, rs=3 -> ALUControl=111, inB=0xFFFFFFFF; ori imm=0xFFFF -> ALUControl=001, inB=0x0000FFFF.
REQ-035 out_ready=0, push 3 bundles back-to-back -> in_ready drops after 2nd accept, 3rd held upstream; outputs stable; release out_ready -> bundles 1,2,3 emerge in order.
REQ-036 Buffer FULL, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, no bundle emitted.
REQ-037 CNT_W=2, accept 5 illegal opcodes (e.g. 0x3F) -> illegal_count 1,2,3,3,3; each output has out_illegal=1, ALUControl=000, inA=inB=0.
REQ-038 Assert rst_n=0 mid-stream while FULL -> outputs immediately at REQ-031 values without a clock edge.
